// File: rtl/spram_pkg.sv
// Shared constants for the single-port RAM arbiter.
// Requester ids, FSM encoding and default widths.
package spram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_HPS  = 1'b0;
  localparam logic REQ_CORE = 1'b1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE_RD = 2'd1;
  localparam logic [1:0] ST_ISSUE_WR = 2'd2;

  function automatic logic [1:0] id2oh(
    input logic id
  );
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-way round-robin selector.
// A lone eligible requester always wins; a tie goes to ~last.
module rr_arb2
  import spram_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       win_valid,
  output logic       win_id
);

  always_comb begin
    win_valid = |eligible;
    win_id    = REQ_HPS;
    unique case (eligible)
      2'b01:   win_id = REQ_HPS;
      2'b10:   win_id = REQ_CORE;
      2'b11:   win_id = ~last;
      default: win_id = REQ_HPS;
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one external single-port RAM
// between the HPS bridge (id 0) and the annealer core (id 1).
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  logic              r_armed;
  logic [1:0]        r_state;
  logic [1:0]        r_gnt;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_pend;
  logic              r_rd_owner;

  logic [1:0]        w_elig;
  logic              w_win_valid;
  logic              w_win_id;
  logic              w_go;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // A requester whose grant is showing is not sampled again.
  assign w_elig = req & ~r_gnt;

  rr_arb2 u_rr (
    .eligible  (w_elig),
    .last      (r_last),
    .win_valid (w_win_valid),
    .win_id    (w_win_id)
  );

  // First edge after reset release only arms the arbiter.
  assign w_go = w_win_valid & r_armed;

  assign w_sel_we = w_win_id ? we[1] : we[0];

  assign w_sel_addr = w_win_id
    ? addr[2*ADDR_W-1:ADDR_W]
    : addr[ADDR_W-1:0];

  assign w_sel_wdata = w_win_id
    ? wdata[2*DATA_W-1:DATA_W]
    : wdata[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_state    <= ST_IDLE;
      r_gnt      <= 2'b00;
      r_last     <= REQ_CORE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= REQ_HPS;
    end else begin
      r_armed    <= 1'b1;
      r_rd_pend  <= (r_state == ST_ISSUE_RD);
      r_rd_owner <= r_last;
      if (w_go) begin
        r_gnt   <= id2oh(w_win_id);
        r_last  <= w_win_id;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_state <= w_sel_we ? ST_ISSUE_WR
                            : ST_ISSUE_RD;
      end else begin
        r_gnt   <= 2'b00;
        r_state <= ST_IDLE;
      end
    end
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    unique case (1'b1)
      (r_state == ST_ISSUE_RD): ram_en = 1'b1;
      (r_state == ST_ISSUE_WR): begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt       = r_gnt;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rvalid    = r_rd_pend ? id2oh(r_rd_owner)
                               : 2'b00;
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed scoreboard bench for spram_arbiter with a
// behavioural single-port RAM attached.
module tb_spram_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  spram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: written cells tracked, others hold a fill pattern.
  logic [31:0] mem [256];
  bit          memv [256];

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'h5A00_0000 | {24'h0, a} | ({24'h0, a} << 12);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]  <= ram_wdata;
        memv[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= memv[ram_addr] ? mem[ram_addr]
                                    : pat(ram_addr);
      end
    end
  end

  typedef struct {
    logic [1:0]  g;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
  } gexp_t;

  typedef struct {
    logic        id;
    logic [31:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  logic [31:0] sh [256];
  bit          shv [256];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    return shv[a] ? sh[a] : pat(a);
  endfunction

  task automatic exp_acc(input logic id, input logic w,
                         input logic [7:0] a,
                         input logic [31:0] d,
                         input bit abort);
    gexp_t g;
    rexp_t r;
    g.g = id ? 2'b10 : 2'b01;
    g.w = w;
    g.a = a;
    g.d = d;
    gq.push_back(g);
    if (w) begin
      sh[a]  = d;
      shv[a] = 1'b1;
    end else if (!abort) begin
      r.id = id;
      r.d  = model_rd(a);
      rq.push_back(r);
    end
  endtask

  task automatic drive(input logic id, input logic w,
                       input logic [7:0] a,
                       input logic [31:0] d);
    req[id]           = 1'b1;
    we[id]            = w;
    addr[id*8 +: 8]   = a;
    wdata[id*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops expectations as grants and read data appear.
  always @(negedge clk) begin
    if (!reset) begin
      chk("en_vs_gnt", {63'h0, ram_en}, {63'h0, (gnt != 2'b00)});
      if (gnt != 2'b00) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", {62'h0, gnt}, 64'h0);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          chk("gnt", {62'h0, gnt}, {62'h0, e.g});
          chk("ram_we", {63'h0, ram_we}, {63'h0, e.w});
          chk("ram_addr", {56'h0, ram_addr}, {56'h0, e.a});
          if (e.w)
            chk("ram_wdata", {32'h0, ram_wdata}, {32'h0, e.d});
        end
      end
      if (rvalid != 2'b00) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", {62'h0, rvalid}, 64'h0);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rvalid", {62'h0, rvalid},
              {62'h0, (e.id ? 2'b10 : 2'b01)});
          chk("rdata", {32'h0, rdata}, {32'h0, e.d});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] gpat;
  int         gcnt;

  initial begin
    reset = 1'b1;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    tick();
    @(negedge clk);
    chk("rst_gnt", {62'h0, gnt}, 64'h0);
    chk("rst_rvalid", {62'h0, rvalid}, 64'h0);
    chk("rst_en_we", {62'h0, ram_en, ram_we}, 64'h0);
    chk("rst_addr", {56'h0, ram_addr}, 64'h0);
    chk("rst_wdata", {32'h0, ram_wdata}, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Single write from the HPS side.
    drive(1'b0, 1'b1, 8'h05, 32'hDEADBEEF);
    exp_acc(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0);
    tick();
    chk("wr_gnt", {62'h0, gnt}, 64'h1);
    req = 2'b00;
    tick();
    chk("idle_en", {62'h0, ram_en, ram_we}, 64'h0);
    chk("idle_hold_addr", {56'h0, ram_addr}, 64'h05);
    chk("wr_no_rvalid", {62'h0, rvalid}, 64'h0);
    tick();
    chk("wr_no_rvalid2", {62'h0, rvalid}, 64'h0);

    // Read back the written word.
    drive(1'b0, 1'b0, 8'h05, 32'h0);
    exp_acc(1'b0, 1'b0, 8'h05, 32'h0, 1'b0);
    tick();
    chk("rd_gnt", {62'h0, gnt}, 64'h1);
    req = 2'b00;
    tick();
    chk("rd_rvalid", {62'h0, rvalid}, 64'h1);
    chk("rd_data", {32'h0, rdata}, 64'hDEADBEEF);
    tick();
    tick();

    // Both requesters reading continuously from reset.
    reset = 1'b1;
    tick();
    drive(1'b0, 1'b0, 8'h20, 32'h0);
    drive(1'b1, 1'b0, 8'h21, 32'h0);
    for (int k = 0; k < 8; k++)
      exp_acc(k[0], 1'b0, k[0] ? 8'h21 : 8'h20, 32'h0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rr_arm_gnt", {62'h0, gnt}, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_en", {63'h0, ram_en}, 64'h1);
      chk("rr_gnt", {62'h0, gnt}, (k % 2 == 1) ? 64'h1 : 64'h2);
    end
    req = 2'b00;
    tick();
    tick();
    tick();

    // Core alone: at most one grant every two cycles.
    drive(1'b1, 1'b0, 8'h30, 32'h0);
    for (int k = 0; k < 3; k++)
      exp_acc(1'b1, 1'b0, 8'h30, 32'h0, 1'b0);
    gpat = '0;
    gcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      gpat[k] = gnt[1];
      if (gnt[1]) gcnt++;
    end
    req = 2'b00;
    chk("solo_pattern", {58'h0, gpat}, 64'h15);
    chk("solo_count", 64'(gcnt), 64'd3);
    tick();
    tick();
    tick();

    // Reset lands on the cycle the read data would return.
    drive(1'b0, 1'b0, 8'h40, 32'h0);
    exp_acc(1'b0, 1'b0, 8'h40, 32'h0, 1'b1);
    tick();
    req = 2'b00;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_rvalid", {62'h0, rvalid}, 64'h0);
    chk("abort_gnt", {62'h0, gnt}, 64'h0);
    chk("abort_en_we", {62'h0, ram_en, ram_we}, 64'h0);
    chk("abort_addr", {56'h0, ram_addr}, 64'h0);
    chk("abort_wdata", {32'h0, ram_wdata}, 64'h0);
    drive(1'b1, 1'b0, 8'h41, 32'h0);
    exp_acc(1'b1, 1'b0, 8'h41, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_gnt0", {62'h0, gnt}, 64'h0);
    tick();
    chk("post_rst_gnt1", {62'h0, gnt}, 64'h2);
    req = 2'b00;
    tick();
    tick();
    tick();

    // Core write then HPS read of the same word, back to back.
    drive(1'b1, 1'b1, 8'h10, 32'hCAFEF00D);
    exp_acc(1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 1'b0);
    tick();
    chk("b2b_wr_gnt", {62'h0, gnt}, 64'h2);
    req = 2'b00;
    drive(1'b0, 1'b0, 8'h10, 32'h0);
    exp_acc(1'b0, 1'b0, 8'h10, 32'h0, 1'b0);
    tick();
    chk("b2b_rd_gnt", {62'h0, gnt}, 64'h1);
    req = 2'b00;
    tick();
    chk("b2b_rvalid", {62'h0, rvalid}, 64'h1);
    chk("b2b_rdata", {32'h0, rdata}, 64'hCAFEF00D);
    repeat (4) tick();

    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the RAM word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the RAM data width.
REQ-003 The module SHALL have port clk, input, 1, the single clock for all state.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port req, input, 2, per-requester access request; bit 0 is the HPS bridge, bit 1 is the annealer core.
REQ-006 The module SHALL have port we, input, 2, per-requester write enable, valid while the matching req bit is high.
REQ-007 The module SHALL have port addr, input, 2*ADDR_W, per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 The module SHALL have port wdata, input, 2*DATA_W, per-requester write data, sliced as for addr.
REQ-009 The module SHALL have port gnt, output, 2, one-cycle grant pulse per requester.
REQ-010 The module SHALL have port rvalid, output, 2, one-cycle read-data-valid pulse per requester.
REQ-011 The module SHALL have port rdata, output, DATA_W, read data shared by both requesters and qualified by rvalid.
REQ-012 The module SHALL have ports ram_en (output, 1), ram_we (output, 1), ram_addr (output, ADDR_W) and ram_wdata (output, DATA_W), which drive the single-port RAM.
REQ-013 The module SHALL have port ram_rdata, input, DATA_W, RAM read data, valid one cycle after ram_en with ram_we low.

Function
REQ-014 In cycle N, an eligible requester SHALL be one whose req is high and whose gnt is low.
REQ-015 At the clk edge ending cycle N, the winner's we, addr and wdata SHALL be registered; in cycle N+1 gnt[winner], ram_en=1 and the registered ram_we, ram_addr and ram_wdata SHALL be driven.
REQ-016 When no requester is eligible, ram_en, ram_we and gnt SHALL be 0 in the next cycle; ram_addr and ram_wdata SHALL hold their last values.
REQ-017 Arbitration SHALL be round-robin. When both requesters are eligible, the one not granted most recently SHALL win, and the last-winner pointer SHALL update only on a grant.
REQ-018 A single eligible requester SHALL win regardless of the pointer.
REQ-019 For a read granted in cycle N+1, rvalid[winner] SHALL pulse in cycle N+2 with rdata equal to ram_rdata of that cycle, passed through combinationally.
REQ-020 A write SHALL never produce rvalid.
REQ-021 Throughput SHALL be one RAM access per cycle: alternating requesters SHALL receive back-to-back grants, and a single requester SHALL receive at most one grant every two cycles.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the arbiter SHALL NOT sample a requester in the cycle its gnt is high.
REQ-023 A read in flight SHALL complete its rvalid even if a new grant issues in the same cycle.
REQ-024 The internal state machine SHALL have states IDLE (no access issued this cycle), ISSUE_RD and ISSUE_WR. Each state SHALL be re-entered from any state on every clk edge according to the arbitration result.
REQ-025 A separate single-bit registered flag with owner id SHALL track the pending read for rvalid.

Reset
REQ-026 While reset is high, gnt, rvalid, ram_en and ram_we SHALL be 0; ram_addr and ram_wdata SHALL be 0; the state SHALL be IDLE; the pending-read flag SHALL be 0; and the last-winner pointer SHALL be 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-access SHALL abort the access: no rvalid SHALL follow for a read issued in the cycle before reset, and the first grant after reset release SHALL occur no earlier than the second clk edge after release.

Structure
REQ-028 The requester-id constants (REQ_HPS=0, REQ_CORE=1), the state encoding and the default ADDR_W/DATA_W SHALL live in the shared package spram_pkg.
REQ-029 The round-robin selector SHALL be a sub-module rr_arb2, with inputs eligible[1:0] and last, and outputs win_valid and win_id.
REQ-030 The RAM itself SHALL be external to this module.

Verification
REQ-031 Reset, then req=01, we0=1, addr0=0x05, wdata0=0xDEADBEEF -> gnt=01 one cycle later with ram_en=1, ram_we=1, ram_addr=0x05, ram_wdata=0xDEADBEEF, and no rvalid.
REQ-032 Req=01 read of addr 0x05 after that write -> gnt[0] in cycle N+1 and rvalid=01 with rdata=0xDEADBEEF in cycle N+2.
REQ-033 Both req held high for 8 cycles, all reads -> gnt sequence 01,10,01,10,... starting with 01 after reset, with ram_en high every cycle after the first.
REQ-034 Req1 held alone for 6 cycles -> gnt[1] high in alternate cycles only, and 3 accesses issued.
REQ-035 Read granted, reset asserted in the rvalid-pending cycle -> rvalid stays 0, all outputs are 0, and after release req=10 is granted first.
REQ-036 Write from requester 1 and read from requester 0 to the same address 0x10 granted back-to-back -> the read returns the newly written data.
